pwm_multichannel_gen: RTL



---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_time_base.sv | 49 ++++
 rtl/pwm_multichannel_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and helpers for the multi-channel PWM generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  // Counting scheme latched at each period boundary
  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Direction of the shared period counter (only DIR_UP is used in edge mode)
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

  // clk cycles per counter tick; a result below 1 means the clock is too slow
  function automatic int calc_res(input int sys_freq, input int pwm_freq,
                                  input int bit_width);
    return (sys_freq / pwm_freq) / (1 << bit_width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_time_base.sv
// ============================================================================
// Module      : pwm_time_base
// Description : Free-running prescaler producing a one-clk tick every RES
//               clocks while enabled; held at zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_time_base #(
  parameter int RES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam int            PW   = (RES > 1) ? $clog2(RES) : 1;
  localparam logic [PW-1:0] LAST = PW'(RES - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  // Next prescaler value: wrap at LAST, park at zero while disabled
  always_comb begin
    presc_d = presc_q;
    if (!en_i) begin
      presc_d = '0;
    end else if (presc_q == LAST) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Prescaler state register
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick_o = en_i && (presc_q == LAST);

endmodule

`default_nettype wire

// File: rtl/pwm_multichannel_gen.sv
// ============================================================================
// Module      : pwm_multichannel_gen
// Description : NUM_CH PWM outputs sharing one prescaler and period counter.
//               Duties are double-buffered (shadow -> active at period
//               boundaries); edge-aligned or centre-aligned counting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_multichannel_gen
  import pwm_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int BIT_WIDTH = 8,
  parameter  int PWM_FREQ  = 100,
  parameter  int SYS_FREQ  = 50000000,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              center_mode,
  input  logic              duty_wr_en,
  input  logic [CH_W-1:0]   duty_wr_ch,
  input  logic [BIT_WIDTH:0] duty_wr_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  localparam int                   RES     = calc_res(SYS_FREQ, PWM_FREQ, BIT_WIDTH);
  localparam int                   DW      = BIT_WIDTH + 1;
  localparam logic [DW-1:0]        MAX     = DW'(1) << BIT_WIDTH;
  localparam logic [BIT_WIDTH-1:0] CNT_TOP = {BIT_WIDTH{1'b1}};

  if (RES < 1) begin : g_res_check
    $error("pwm_multichannel_gen: SYS_FREQ too low for PWM_FREQ and BIT_WIDTH");
  end

  logic                 en_q;
  logic [BIT_WIDTH-1:0] cnt_q, cnt_d;
  cnt_dir_e             dir_q, dir_d;
  pwm_mode_e            mode_q, mode_d;
  logic                 period_start_q, period_start_d;
  logic                 run;
  logic                 tick;
  logic                 boundary;
  logic                 load;
  logic [DW-1:0]        wr_duty_sat;

  // The first enabled clk only emits period_start; counting starts a clk later
  // so every period, including the first, spans exactly one full period.
  assign run = enable & en_q;

  pwm_time_base #(
    .RES (RES)
  ) u_time_base (
    .clk    (clk),
    .reset  (reset),
    .en_i   (run),
    .tick_o (tick)
  );

  // Period counter next state; flags the tick that ends a period
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (!enable) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      if (mode_q == PWM_EDGE) begin
        if (cnt_q == CNT_TOP) begin
          cnt_d    = '0;
          dir_d    = DIR_UP;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + BIT_WIDTH'(1);
        end
      end else if (dir_q == DIR_UP) begin
        // hold one tick at the top while turning round
        if (cnt_q == CNT_TOP) begin
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + BIT_WIDTH'(1);
        end
      end else begin
        // hold one tick at zero; the down->up turn is the period boundary
        if (cnt_q == '0) begin
          dir_d    = DIR_UP;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - BIT_WIDTH'(1);
        end
      end
    end
  end

  // Shadow duties and mode are transferred while idle and at each boundary
  assign load = ~run | boundary;

  // Mode latch and period_start pulse next state
  always_comb begin
    mode_d         = load ? (center_mode ? PWM_CENTER : PWM_EDGE) : mode_q;
    period_start_d = boundary | (enable & ~en_q);
  end

  // Shared counter, mode and period_start state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q           <= 1'b0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      mode_q         <= PWM_EDGE;
      period_start_q <= 1'b0;
    end else begin
      en_q           <= enable;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      mode_q         <= mode_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  // Duties above MAX would behave like MAX anyway; clamp so shadow stays in range
  assign wr_duty_sat = (duty_wr_data > MAX) ? MAX : duty_wr_data;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DW-1:0] shadow_q;
    logic [DW-1:0] active_q;
    logic          pwm_q;

    // Per-channel shadow/active duty and registered compare output
    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_q <= '0;
        active_q <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (duty_wr_en && (duty_wr_ch == CH_W'(i))) begin
          shadow_q <= wr_duty_sat;
        end
        if (load) begin
          active_q <= shadow_q;
        end
        pwm_q <= run & ({1'b0, cnt_q} < active_q);
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

`default_nettype wire
